qam_carrier_nco: RTL

Numerically controlled oscillator that generates the quadrature carrier (sin, cos, zero flag) consumed by the QAM multiplier stage, which forms I·cos − Q·sin. A phase accumulator drives a quarter-wave sine ROM with quadrant mirroring. The zero flag marks the first sample of every carrier period, so the multiplier can align modulation start to phase 0. The block sits directly upstream of the multiplier on the carrier interface.

---
 rtl/qam_carrier_nco_pkg.sv | 21 ++
 rtl/qam_sine_rom.sv | 48 ++++
 rtl/qam_carrier_nco.sv | 126 ++++++++++++
 3 files changed

// File: rtl/qam_carrier_nco_pkg.sv
// Shared constants and types for the QAM carrier NCO.
package parameter_def;

  localparam int CARRIER_WIDTH = 8;   // signed 1Q6, +1.0 = 64
  localparam int PHASE_WIDTH   = 16;
  localparam int ROM_DEPTH     = 65;  // quarter wave plus the 90-degree endpoint
  localparam int ADDR_W        = 8;   // phase bits used for ROM addressing
  localparam int IDX_W         = $clog2(ROM_DEPTH);
  localparam int MAG_W         = CARRIER_WIDTH - 1;
  localparam int STAGES        = 3;   // S1 decode, S2 ROM, S3 mirror/output

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

  typedef struct packed {
    logic signed [CARRIER_WIDTH-1:0] sin;
    logic signed [CARRIER_WIDTH-1:0] cos;
    logic                            zero;
    logic                            valid;
  } carrier_t;

endpackage

// File: rtl/qam_sine_rom.sv
// Quarter-wave sine magnitude ROM, two registered read ports.
module qam_sine_rom
  import parameter_def::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] sin_idx_i,
  input  logic [IDX_W-1:0] cos_idx_i,
  output logic [MAG_W-1:0] sin_mag_o,
  output logic [MAG_W-1:0] cos_mag_o
);

  // round(64*sin(2*pi*k/256)), k = 0..64
  function automatic logic [MAG_W-1:0] lut(input logic [IDX_W-1:0] k);
    case (k)
      7'd0:  lut = 7'd0;  7'd1:  lut = 7'd2;  7'd2:  lut = 7'd3;  7'd3:  lut = 7'd5;
      7'd4:  lut = 7'd6;  7'd5:  lut = 7'd8;  7'd6:  lut = 7'd9;  7'd7:  lut = 7'd11;
      7'd8:  lut = 7'd12; 7'd9:  lut = 7'd14; 7'd10: lut = 7'd16; 7'd11: lut = 7'd17;
      7'd12: lut = 7'd19; 7'd13: lut = 7'd20; 7'd14: lut = 7'd22; 7'd15: lut = 7'd23;
      7'd16: lut = 7'd24; 7'd17: lut = 7'd26; 7'd18: lut = 7'd27; 7'd19: lut = 7'd29;
      7'd20: lut = 7'd30; 7'd21: lut = 7'd32; 7'd22: lut = 7'd33; 7'd23: lut = 7'd34;
      7'd24: lut = 7'd36; 7'd25: lut = 7'd37; 7'd26: lut = 7'd38; 7'd27: lut = 7'd39;
      7'd28: lut = 7'd41; 7'd29: lut = 7'd42; 7'd30: lut = 7'd43; 7'd31: lut = 7'd44;
      7'd32: lut = 7'd45; 7'd33: lut = 7'd46; 7'd34: lut = 7'd47; 7'd35: lut = 7'd48;
      7'd36: lut = 7'd49; 7'd37: lut = 7'd50; 7'd38: lut = 7'd51; 7'd39: lut = 7'd52;
      7'd40: lut = 7'd53; 7'd41: lut = 7'd54; 7'd42: lut = 7'd55; 7'd43: lut = 7'd56;
      7'd44: lut = 7'd56; 7'd45: lut = 7'd57; 7'd46: lut = 7'd58; 7'd47: lut = 7'd59;
      7'd48: lut = 7'd59; 7'd49: lut = 7'd60; 7'd50: lut = 7'd60; 7'd51: lut = 7'd61;
      7'd52: lut = 7'd61; 7'd53: lut = 7'd62; 7'd54: lut = 7'd62; 7'd55: lut = 7'd62;
      7'd56: lut = 7'd63; 7'd57: lut = 7'd63; 7'd58: lut = 7'd63; 7'd59: lut = 7'd64;
      7'd60: lut = 7'd64; 7'd61: lut = 7'd64; 7'd62: lut = 7'd64; 7'd63: lut = 7'd64;
      7'd64: lut = 7'd64;
      default: lut = '0;
    endcase
  endfunction

  // Registered read of both ports
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sin_mag_o <= '0;
      cos_mag_o <= '0;
    end else begin
      sin_mag_o <= lut(sin_idx_i);
      cos_mag_o <= lut(cos_idx_i);
    end
  end

endmodule

// File: rtl/qam_carrier_nco.sv
// Quadrature carrier NCO: phase accumulator, quarter-wave ROM, 3-cycle pipeline.
module qam_carrier_nco
  import parameter_def::*;
#(
  parameter logic [PHASE_WIDTH-1:0] DEFAULT_INC = 16'h1000
) (
  input  logic                   axi_clk,
  input  logic                   axi_rst,
  input  logic                   enable,
  input  logic                   phase_clr,
  input  logic [PHASE_WIDTH-1:0] phase_inc,
  input  logic                   phase_inc_load,
  output carrier_t               cor
);

  logic [PHASE_WIDTH-1:0] acc_q, acc_d, inc_q, inc_d, pend_inc_q, pend_inc_d;
  logic                   pend_q, pend_d, wrap_q, wrap_d;
  logic [PHASE_WIDTH-1:0] sum;
  logic                   carry, boundary;

  // Map a quadrant/index to the ROM slot; odd quadrants read the quarter backwards
  function automatic logic [IDX_W-1:0] mirror_idx(input quad_e q, input logic [ADDR_W-3:0] i);
    case (q)
      Q1, Q3:  mirror_idx = IDX_W'(ROM_DEPTH - 1) - IDX_W'(i);
      default: mirror_idx = IDX_W'(i);
    endcase
  endfunction

  // Next-state for accumulator, period-start flag and increment reload
  always_comb begin
    acc_d      = acc_q;
    inc_d      = inc_q;
    pend_d     = pend_q;
    pend_inc_d = pend_inc_q;
    wrap_d     = wrap_q;
    {carry, sum} = {1'b0, acc_q} + {1'b0, inc_q};
    // a clear counts as a period boundary, so a pending increment lands with it
    boundary = phase_clr | (enable & carry);

    if (phase_clr) begin
      acc_d  = '0;
      wrap_d = 1'b1;
    end else if (enable) begin
      acc_d  = sum;
      wrap_d = carry;   // the current sample consumes the flag unless we wrap again
    end

    if (phase_inc_load) begin
      if (!enable || boundary) begin
        inc_d  = phase_inc;
        pend_d = 1'b0;
      end else begin
        pend_d     = 1'b1;
        pend_inc_d = phase_inc;
      end
    end else if (pend_q && boundary) begin
      inc_d  = pend_inc_q;
      pend_d = 1'b0;
    end
  end

  // Accumulator state register (S0)
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      acc_q      <= '0;
      inc_q      <= DEFAULT_INC;
      pend_q     <= 1'b0;
      pend_inc_q <= '0;
      wrap_q     <= 1'b1;   // first sample after reset is a period start
    end else begin
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      pend_q     <= pend_d;
      pend_inc_q <= pend_inc_d;
      wrap_q     <= wrap_d;
    end
  end

  // S1 decode: cosine is the same address advanced one quadrant
  logic [ADDR_W-1:0] addr;
  quad_e             sin_quad, cos_quad;
  assign addr     = acc_q[PHASE_WIDTH-1 -: ADDR_W];
  assign sin_quad = quad_e'(addr[ADDR_W-1 -: 2]);
  assign cos_quad = quad_e'(addr[ADDR_W-1 -: 2] + 2'd1);

  logic [STAGES:1] vld_pipe_q, zero_pipe_q;
  logic [IDX_W-1:0] s1_sin_idx_q, s1_cos_idx_q;
  logic [2:1]       sin_neg_q, cos_neg_q;
  logic [MAG_W-1:0] sin_mag, cos_mag;
  logic signed [CARRIER_WIDTH-1:0] sin_q, cos_q;

  qam_sine_rom u_rom (
    .clk_i     (axi_clk),
    .rst_i     (axi_rst),
    .sin_idx_i (s1_sin_idx_q),
    .cos_idx_i (s1_cos_idx_q),
    .sin_mag_o (sin_mag),
    .cos_mag_o (cos_mag)
  );

  // Pipeline S1..S3: decode, ROM (in sub-module), mirror/negate; valid/zero ride alongside
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      vld_pipe_q   <= '0;
      zero_pipe_q  <= '0;
      s1_sin_idx_q <= '0;
      s1_cos_idx_q <= '0;
      sin_neg_q    <= '0;
      cos_neg_q    <= '0;
      sin_q        <= '0;
      cos_q        <= '0;
    end else begin
      vld_pipe_q   <= {vld_pipe_q[STAGES-1:1], enable};
      zero_pipe_q  <= {zero_pipe_q[STAGES-1:1], enable & wrap_q};
      s1_sin_idx_q <= mirror_idx(sin_quad, addr[ADDR_W-3:0]);
      s1_cos_idx_q <= mirror_idx(cos_quad, addr[ADDR_W-3:0]);
      sin_neg_q    <= {sin_neg_q[1], sin_quad inside {Q2, Q3}};
      cos_neg_q    <= {cos_neg_q[1], cos_quad inside {Q2, Q3}};
      sin_q        <= sin_neg_q[2] ? -{1'b0, sin_mag} : {1'b0, sin_mag};
      cos_q        <= cos_neg_q[2] ? -{1'b0, cos_mag} : {1'b0, cos_mag};
    end
  end

  assign cor = '{sin: sin_q, cos: cos_q, zero: zero_pipe_q[STAGES], valid: vld_pipe_q[STAGES]};

endmodule
